// File: rtl/pe_force_collect_scheduler_if.sv
// PE result streams and force write-back head for one cell's collect scheduler.
interface pe_force_collect_scheduler_if #(
   parameter int unsigned NUM_PES     = 4,
   parameter int unsigned DATA_WIDTH  = 96,
   parameter int unsigned PE_ID_WIDTH = $clog2(NUM_PES)
);
   logic [NUM_PES-1:0]            i_pe_valid;
   logic [NUM_PES*DATA_WIDTH-1:0] i_pe_data;
   logic [NUM_PES-1:0]            i_pe_last;
   logic [NUM_PES-1:0]            o_pe_ready;
   logic                          o_valid;
   logic [DATA_WIDTH-1:0]         o_data;
   logic [PE_ID_WIDTH-1:0]        o_pe_id;
   logic                          i_ready;

   modport master (
      input  i_pe_valid, i_pe_data, i_pe_last, i_ready,
      output o_pe_ready, o_valid, o_data, o_pe_id
   );

   modport slave (
      output i_pe_valid, i_pe_data, i_pe_last, i_ready,
      input  o_pe_ready, o_valid, o_data, o_pe_id
   );
endinterface

// File: rtl/pe_force_collect_scheduler.sv
// Round-robin collects PE force results into a FWFT FIFO and sequences
// the collect/drain/done phases of each force-evaluation frame.
module pe_force_collect_scheduler #(
   parameter int unsigned NUM_PES     = 4,
   parameter int unsigned DATA_WIDTH  = 96,
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter int unsigned PE_ID_WIDTH = $clog2(NUM_PES)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_start,
   pe_force_collect_scheduler_if.master bus,
   output logic [$clog2(FIFO_DEPTH):0]  o_fifo_count,
   output logic                         o_busy,
   output logic                         o_done
);
   localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = ADDR_W + 1;

   typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

   typedef struct packed {
      logic [PE_ID_WIDTH-1:0] id;
      logic [DATA_WIDTH-1:0]  data;
   } entry_t;

   state_t                 state_q, state_d;
   logic [PE_ID_WIDTH-1:0] ptr_q;
   logic [NUM_PES-1:0]     last_q;
   logic                   busy_q, done_q;

   logic [NUM_PES-1:0]     eligible_c, grant_c, last_set_c;
   logic [PE_ID_WIDTH-1:0] grant_id_c, idx_c;
   logic                   found_c, push_c, pop_c;
   entry_t                 push_entry_c, head_c;

   entry_t                 mem_q [FIFO_DEPTH];
   logic [ADDR_W-1:0]      wr_q, rd_q;
   logic [CNT_W-1:0]       count_q, count_d;
   logic                   valid_q;

   assign eligible_c = bus.i_pe_valid & ~last_q;

   // Rotating-priority search from ptr_q; a slot freed by a same-cycle pop is not reused
   always_comb begin
      grant_c    = '0;
      grant_id_c = '0;
      idx_c      = '0;
      found_c    = 1'b0;
      if (state_q == COLLECT && count_q < CNT_W'(FIFO_DEPTH)) begin
         for (int unsigned i = 0; i < NUM_PES; i++) begin
            idx_c = PE_ID_WIDTH'((32'(ptr_q) + i) % NUM_PES);
            if (!found_c && eligible_c[idx_c]) begin
               grant_c[idx_c] = 1'b1;
               grant_id_c     = idx_c;
               found_c        = 1'b1;
            end
         end
      end
   end

   assign push_c       = |grant_c;
   assign last_set_c   = grant_c & bus.i_pe_last;
   assign pop_c        = valid_q & bus.i_ready;
   assign count_d      = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
   assign push_entry_c = '{id:   grant_id_c,
                           data: bus.i_pe_data[32'(grant_id_c)*DATA_WIDTH +: DATA_WIDTH]};

   // Frame sequencing; the last flag set on this edge counts toward leaving COLLECT
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (i_start) state_d = COLLECT;
         COLLECT: if (&(last_q | last_set_c)) state_d = DRAIN;
         DRAIN:   if (count_q == '0) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         last_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d != IDLE);
         done_q  <= (state_d == DONE);
         if (state_q == IDLE && i_start) last_q <= '0;
         else                            last_q <= last_q | last_set_c;
         if (push_c) ptr_q <= PE_ID_WIDTH'((32'(grant_id_c) + 1) % NUM_PES);
      end
   end

   // FIFO bookkeeping; storage itself needs no reset since the head is gated by valid
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
      end else begin
         if (push_c) wr_q <= wr_q + ADDR_W'(1);
         if (pop_c)  rd_q <= rd_q + ADDR_W'(1);
         count_q <= count_d;
         valid_q <= (count_d != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (push_c) mem_q[wr_q] <= push_entry_c;
   end

   assign head_c         = mem_q[rd_q];
   assign bus.o_pe_ready = grant_c;
   assign bus.o_valid    = valid_q;
   assign bus.o_data     = valid_q ? head_c.data : '0;
   assign bus.o_pe_id    = valid_q ? head_c.id : '0;
   assign o_fifo_count   = count_q;
   assign o_busy         = busy_q;
   assign o_done         = done_q;
endmodule

// File: tb/tb_pe_force_collect_scheduler.sv
// Directed bench for pe_force_collect_scheduler with hand-computed expectations.
module tb_pe_force_collect_scheduler;
   localparam int unsigned NUM_PES     = 4;
   localparam int unsigned DATA_WIDTH  = 96;
   localparam int unsigned FIFO_DEPTH  = 8;
   localparam int unsigned PE_ID_WIDTH = 2;
   localparam int unsigned CNT_W       = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             i_start;
   logic [CNT_W-1:0] o_fifo_count;
   logic             o_busy;
   logic             o_done;

   int n_checks = 0;
   int n_errors = 0;
   int sent [NUM_PES];
   int exp_g [8] = '{1, 2, 3, 0, 1, 2, 3, 0};

   pe_force_collect_scheduler_if #(
      .NUM_PES(NUM_PES), .DATA_WIDTH(DATA_WIDTH), .PE_ID_WIDTH(PE_ID_WIDTH)
   ) bus ();

   pe_force_collect_scheduler #(
      .NUM_PES(NUM_PES), .DATA_WIDTH(DATA_WIDTH),
      .FIFO_DEPTH(FIFO_DEPTH), .PE_ID_WIDTH(PE_ID_WIDTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_start      (i_start),
      .bus          (bus),
      .o_fifo_count (o_fifo_count),
      .o_busy       (o_busy),
      .o_done       (o_done)
   );

   always #5 clk = ~clk;

   function automatic logic [DATA_WIDTH-1:0] word(input int k);
      return {32'(k + 1), 32'hF00D_0000 | 32'(k), 32'hCAFE_0000 | 32'(k)};
   endfunction

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic next();
      @(negedge clk);
   endtask

   initial begin
      rst            = 1'b0;
      i_start        = 1'b0;
      bus.i_pe_valid = '0;
      bus.i_pe_last  = '0;
      bus.i_ready    = 1'b0;
      for (int k = 0; k < NUM_PES; k++) bus.i_pe_data[k*DATA_WIDTH +: DATA_WIDTH] = word(k);

      // reset state
      next(); next(); #1;
      check("rst_valid", 128'(bus.o_valid), 128'(0));
      check("rst_busy", 128'(o_busy), 128'(0));
      check("rst_done", 128'(o_done), 128'(0));
      check("rst_ready", 128'(bus.o_pe_ready), 128'(0));
      check("rst_count", 128'(o_fifo_count), 128'(0));
      check("rst_data", 128'(bus.o_data), 128'(0));
      next(); rst = 1'b1;

      // fairness: all PEs valid, downstream always ready
      next(); i_start = 1'b1; bus.i_ready = 1'b1; #1;
      check("idle_ready", 128'(bus.o_pe_ready), 128'(0));
      check("idle_busy", 128'(o_busy), 128'(0));
      next(); i_start = 1'b0; bus.i_pe_valid = 4'hF;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) next();
         #1;
         check("fair_ready", 128'(bus.o_pe_ready), 128'(1 << (i % 4)));
         check("fair_valid", 128'(bus.o_valid), 128'(i > 0));
         if (i > 0) begin
            check("fair_id", 128'(bus.o_pe_id), 128'((i - 1) % 4));
            check("fair_data", 128'(bus.o_data), 128'(word((i - 1) % 4)));
            check("fair_count", 128'(o_fifo_count), 128'(1));
         end
      end
      next(); bus.i_pe_valid = '0; #1;
      check("fair_tail_id", 128'(bus.o_pe_id), 128'(3));
      check("fair_tail_ready", 128'(bus.o_pe_ready), 128'(0));
      next(); #1;
      check("fair_empty_count", 128'(o_fifo_count), 128'(0));
      check("fair_empty_valid", 128'(bus.o_valid), 128'(0));

      // backpressure: fill to FIFO_DEPTH, single pop, one refill grant
      next(); bus.i_ready = 1'b0; bus.i_pe_valid = 4'hF;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) next();
         #1;
         check("bp_ready", 128'(bus.o_pe_ready), 128'(1 << (i % 4)));
         check("bp_count", 128'(o_fifo_count), 128'(i));
      end
      next(); #1;
      check("bp_full_ready", 128'(bus.o_pe_ready), 128'(0));
      check("bp_full_count", 128'(o_fifo_count), 128'(8));
      check("bp_full_id", 128'(bus.o_pe_id), 128'(0));
      check("bp_full_valid", 128'(bus.o_valid), 128'(1));
      next(); #1;
      check("bp_hold_id", 128'(bus.o_pe_id), 128'(0));
      check("bp_hold_data", 128'(bus.o_data), 128'(word(0)));
      bus.i_ready = 1'b1; #1;
      check("bp_pop_noready", 128'(bus.o_pe_ready), 128'(0));
      next(); bus.i_ready = 1'b0; #1;
      check("bp_after_pop_count", 128'(o_fifo_count), 128'(7));
      check("bp_refill_ready", 128'(bus.o_pe_ready), 128'(4'b0001));
      check("bp_after_pop_id", 128'(bus.o_pe_id), 128'(1));
      next(); bus.i_pe_valid = '0; #1;
      check("bp_refull_count", 128'(o_fifo_count), 128'(8));
      check("bp_refull_ready", 128'(bus.o_pe_ready), 128'(0));
      bus.i_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("bp_drain_id", 128'(bus.o_pe_id), 128'((i + 1) % 4));
         check("bp_drain_count", 128'(o_fifo_count), 128'(8 - i));
         next(); #1;
      end
      check("bp_drained_count", 128'(o_fifo_count), 128'(0));
      check("bp_drained_valid", 128'(bus.o_valid), 128'(0));

      // skip and wrap of the priority pointer
      bus.i_pe_valid = 4'b0010; #1;
      check("skip_ready_a", 128'(bus.o_pe_ready), 128'(4'b0010));
      next(); #1;
      check("skip_ready_b", 128'(bus.o_pe_ready), 128'(4'b0010));
      check("skip_id_a", 128'(bus.o_pe_id), 128'(1));
      next(); bus.i_pe_valid = 4'b1001; #1;
      check("wrap_ready_3", 128'(bus.o_pe_ready), 128'(4'b1000));
      check("skip_id_b", 128'(bus.o_pe_id), 128'(1));
      next(); #1;
      check("wrap_ready_0", 128'(bus.o_pe_ready), 128'(4'b0001));
      check("wrap_id_3", 128'(bus.o_pe_id), 128'(3));
      next(); bus.i_pe_valid = '0; #1;
      check("wrap_id_0", 128'(bus.o_pe_id), 128'(0));
      check("wrap_idle_ready", 128'(bus.o_pe_ready), 128'(0));
      next(); #1;
      check("wrap_empty", 128'(o_fifo_count), 128'(0));

      // frame end: two results per PE, second marked last; stray start mid-frame
      for (int k = 0; k < NUM_PES; k++) sent[k] = 0;
      bus.i_pe_valid = 4'hF;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) next();
         for (int k = 0; k < NUM_PES; k++) bus.i_pe_last[k] = (sent[k] == 1);
         i_start = (i == 5);
         #1;
         check("fe_ready", 128'(bus.o_pe_ready), 128'(1 << exp_g[i]));
         if (i > 0) begin
            check("fe_id", 128'(bus.o_pe_id), 128'(exp_g[i - 1]));
            check("fe_count", 128'(o_fifo_count), 128'(1));
         end
         for (int k = 0; k < NUM_PES; k++) if (bus.o_pe_ready[k]) sent[k]++;
      end
      next(); #1;
      check("fe_drain_ready", 128'(bus.o_pe_ready), 128'(0));
      check("fe_drain_busy", 128'(o_busy), 128'(1));
      check("fe_drain_done", 128'(o_done), 128'(0));
      check("fe_drain_id", 128'(bus.o_pe_id), 128'(0));
      check("fe_drain_count", 128'(o_fifo_count), 128'(1));
      next(); #1;
      check("fe_empty_count", 128'(o_fifo_count), 128'(0));
      check("fe_empty_done", 128'(o_done), 128'(0));
      check("fe_empty_busy", 128'(o_busy), 128'(1));
      next(); #1;
      check("fe_done_pulse", 128'(o_done), 128'(1));
      check("fe_done_busy", 128'(o_busy), 128'(1));
      next(); #1;
      check("fe_idle_done", 128'(o_done), 128'(0));
      check("fe_idle_busy", 128'(o_busy), 128'(0));
      check("fe_idle_ready", 128'(bus.o_pe_ready), 128'(0));

      // async reset mid-COLLECT with five entries buffered
      next(); i_start = 1'b1; bus.i_ready = 1'b0; bus.i_pe_last = '0; #1;
      check("ar_idle_ready", 128'(bus.o_pe_ready), 128'(0));
      next(); i_start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) next();
         #1;
         check("ar_ready", 128'(bus.o_pe_ready), 128'(1 << ((1 + i) % 4)));
      end
      next(); #1;
      check("ar_count5", 128'(o_fifo_count), 128'(5));
      check("ar_valid1", 128'(bus.o_valid), 128'(1));
      #2 rst = 1'b0; #1;
      check("ar_valid", 128'(bus.o_valid), 128'(0));
      check("ar_busy", 128'(o_busy), 128'(0));
      check("ar_ready0", 128'(bus.o_pe_ready), 128'(0));
      check("ar_count", 128'(o_fifo_count), 128'(0));
      check("ar_data", 128'(bus.o_data), 128'(0));
      next(); rst = 1'b1; #1;
      check("ar_rel_ready", 128'(bus.o_pe_ready), 128'(0));
      check("ar_rel_busy", 128'(o_busy), 128'(0));
      next(); i_start = 1'b1;
      next(); i_start = 1'b0; #1;
      check("ar_ptr_zero", 128'(bus.o_pe_ready), 128'(4'b0001));
      check("ar_new_busy", 128'(o_busy), 128'(1));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
